// File: rtl/mul_share_arbiter.sv
// Shares one multiply datapath between two requesters: round-robin grant, operand capture,
// start pulse, done/timeout wait, then a valid/ready result return to the winning requester.
module mul_share_arbiter #(
  parameter int WIDTH   = 16,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic [1:0]       rvalid,
  output logic [RES_W-1:0] rdata,
  output logic             rerr,
  input  logic [1:0]       rready,
  output logic             dp_start,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic             dp_done,
  input  logic [RES_W-1:0] dp_result,
  output logic             dp_rst,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // The counter reaches TIMEOUT on the edge that leaves BUSY, so compare one below it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [RES_W-1:0] rdata_q, rdata_d;
  logic             rerr_q, rerr_d;
  logic             dprst_q, dprst_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             winner;

  // With both requesting, the one not served last wins; otherwise the lone requester.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = ~last_q;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    dprst_d = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          owner_d = winner;
          a_d     = winner ? a1 : a0;
          b_d     = winner ? b1 : b0;
          gnt_d   = winner ? 2'b10 : 2'b01;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dp_done) begin
          rdata_d = dp_result;
          rerr_d  = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
          dprst_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rready[owner_q]) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      dprst_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      dprst_q <= dprst_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rdata    = rdata_q;
  assign rerr     = rerr_q;
  assign dp_start = (state_q == START);
  assign dp_a     = a_q;
  assign dp_b     = b_q;
  assign dp_rst   = dprst_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: transaction-timeline reference model, emulated datapath,
// directed scenarios with literal expectations and a randomized phase.
module tb_mul_share_arbiter;

  localparam int WIDTH = 16;
  localparam int RES_W = 16;
  localparam int TO    = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]       rready = 2'b00;
  logic             dp_done = 1'b0;
  logic [RES_W-1:0] dp_result = '0;
  logic [1:0]       gnt, rvalid;
  logic [RES_W-1:0] rdata;
  logic             rerr, dp_start, dp_rst, busy;
  logic [WIDTH-1:0] dp_a, dp_b;

  int errors = 0;
  int checks = 0;
  int latCfg = 1;
  bit strayEn = 1'b0;

  mul_share_arbiter #(.WIDTH(WIDTH), .RES_W(RES_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rerr(rerr), .rready(rready),
    .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b),
    .dp_done(dp_done), .dp_result(dp_result), .dp_rst(dp_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] mulRef(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] p;
    p = x * y;
    return p[RES_W-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] y0,
                               input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] y1, input logic [1:0] rr);
    req = r; a0 = x0; b0 = y0; a1 = x1; b1 = y1; rready = rr;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    #1 rst = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    stepCycle();
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic [1:0]       sReq = 2'b00, sRready = 2'b00;
  logic [WIDTH-1:0] sA0 = '0, sB0 = '0, sA1 = '0, sB1 = '0;
  int               sLat = 1;
  logic             sRst = 1'b1;

  always @(posedge clk) begin
    sReq <= req; sRready <= rready;
    sA0 <= a0; sB0 <= b0; sA1 <= a1; sB1 <= b1;
    sLat <= latCfg; sRst <= rst;
  end

  // Model: one transaction described by its grant cycle, response cycle and outcome.
  int               cyc = 0;
  bit               mActive = 1'b0;
  int               mG = 0, mRespAt = 0, mLat = 0;
  logic             mOwner = 1'b0, mLast = 1'b1;
  logic [WIDTH-1:0] mA = '0, mB = '0;
  logic [RES_W-1:0] mData = '0, hData = '0;
  logic             mErr = 1'b0, hErr = 1'b0;
  bit               pend = 1'b0;
  int               pendAt = 0;

  initial begin
    logic       w;
    bit         ok, inResp;
    logic [1:0] ohot;
    forever begin
      @(negedge clk);
      if (rst || sRst) begin
        mActive = 1'b0; mLast = 1'b1; mOwner = 1'b0; mA = '0; mB = '0;
        hData = '0; hErr = 1'b0; mLat = 0; pend = 1'b0;
      end else if (!mActive) begin
        if (sReq != 2'b00) begin
          w = (sReq[0] && sReq[1]) ? !mLast : sReq[1];
          mActive = 1'b1; mOwner = w; mG = cyc + 1;
          mA = w ? sA1 : sA0;
          mB = w ? sB1 : sB0;
          mLat = sLat;
          ok = (mLat != 0) && (mLat <= TO);
          mData = ok ? mulRef(mA, mB) : '0;
          mErr = !ok;
          mRespAt = mG + 1 + (ok ? mLat : TO);
        end
      end else if (cyc >= mRespAt && sRready[mOwner]) begin
        mActive = 1'b0; mLast = mOwner; hData = mData; hErr = mErr;
      end
      cyc++;

      ohot   = mOwner ? 2'b10 : 2'b01;
      inResp = mActive && (cyc >= mRespAt);
      checkOutput("gnt", 32'(gnt), 32'((mActive && cyc == mG) ? ohot : 2'b00));
      checkOutput("dp_start", 32'(dp_start), 32'(mActive && cyc == mG));
      checkOutput("busy", 32'(busy), 32'(mActive));
      checkOutput("rvalid", 32'(rvalid), 32'(inResp ? ohot : 2'b00));
      checkOutput("rdata", 32'(rdata), 32'(inResp ? mData : hData));
      checkOutput("rerr", 32'(rerr), 32'(inResp ? mErr : hErr));
      checkOutput("dp_rst", 32'(dp_rst), 32'(mActive && cyc == mRespAt && mErr));
      checkOutput("dp_a", 32'(dp_a), 32'(mA));
      checkOutput("dp_b", 32'(dp_b), 32'(mB));

      // Datapath emulation; stray done pulses are kept out of the BUSY window.
      if (rst) begin
        pend = 1'b0; dp_done = 1'b0;
      end else begin
        if (pend && cyc == pendAt) begin
          dp_done = 1'b1; dp_result = mulRef(dp_a, dp_b); pend = 1'b0;
        end else if (strayEn && !(mActive && cyc > mG && cyc < mRespAt) && $urandom_range(0, 5) == 0) begin
          dp_done = 1'b1; dp_result = RES_W'($urandom);
        end else begin
          dp_done = 1'b0; dp_result = RES_W'($urandom);
        end
        if (dp_start && mLat != 0) begin
          pend = 1'b1; pendAt = cyc + mLat;
        end
      end
    end
  end

  initial begin
    int         n, k;
    bit         sawRst, stableOk, sawGnt;
    logic [RES_W-1:0] held;
    logic [1:0] gntSeq [4];
    logic [1:0] expSeq [4];
    logic [1:0] nr;
    int         pick;
    expSeq = '{2'b01, 2'b10, 2'b01, 2'b10};
    gntSeq = '{2'b00, 2'b00, 2'b00, 2'b00};

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_rvalid", 32'(rvalid), 32'h0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] single request");
    latCfg = 10;
    applyStimulus(2'b01, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 2'b00);
    stepCycle();
    checkOutput("single_gnt", 32'(gnt), 32'h1);
    checkOutput("single_dp_start", 32'(dp_start), 32'h1);
    checkOutput("single_dp_a", 32'(dp_a), 32'h3);
    checkOutput("single_dp_b", 32'(dp_b), 32'h5);
    req = 2'b00;
    n = 0;
    while (rvalid == 2'b00 && n < 100) begin stepCycle(); n++; end
    checkOutput("single_latency", 32'(n), 32'd11);
    checkOutput("single_rvalid", 32'(rvalid), 32'h1);
    checkOutput("single_rdata", 32'(rdata), 32'h000F);
    checkOutput("single_rerr", 32'(rerr), 32'h0);
    rready = 2'b01;
    stepCycle();
    checkOutput("single_rvalid_clear", 32'(rvalid), 32'h0);
    rready = 2'b00;

    $display("[TB] simultaneous requests after reset");
    doReset();
    latCfg = 3;
    applyStimulus(2'b11, 16'h0011, 16'h0002, 16'h0021, 16'h0003, 2'b11);
    k = 0; n = 0;
    while (k < 4 && n < 200) begin
      stepCycle(); n++;
      if (gnt != 2'b00) begin gntSeq[k] = gnt; k++; end
    end
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rr_grant%0d", i), 32'(gntSeq[i]), 32'(expSeq[i]));
    req = 2'b00;
    n = 0;
    while (busy && n < 100) begin stepCycle(); n++; end
    rready = 2'b00;

    $display("[TB] timeout");
    latCfg = 0;
    applyStimulus(2'b01, 16'h1234, 16'h0077, 16'h0000, 16'h0000, 2'b00);
    n = 0;
    while (!dp_start && n < 10) begin stepCycle(); n++; end
    req = 2'b00;
    n = 0;
    while (!dp_rst && n < 100) begin stepCycle(); n++; end
    checkOutput("timeout_dp_rst_delay", 32'(n), 32'd21);
    checkOutput("timeout_rvalid", 32'(rvalid), 32'h1);
    checkOutput("timeout_rerr", 32'(rerr), 32'h1);
    checkOutput("timeout_rdata", 32'(rdata), 32'h0);
    rready = 2'b01;
    stepCycle();
    rready = 2'b00;

    $display("[TB] done on the timeout cycle");
    latCfg = TO;
    applyStimulus(2'b01, 16'h0102, 16'h0304, 16'h0000, 16'h0000, 2'b00);
    n = 0;
    while (!dp_start && n < 10) begin stepCycle(); n++; end
    req = 2'b00;
    n = 0; sawRst = 1'b0;
    while (rvalid == 2'b00 && n < 100) begin stepCycle(); n++; if (dp_rst) sawRst = 1'b1; end
    checkOutput("collision_latency", 32'(n), 32'd21);
    checkOutput("collision_rerr", 32'(rerr), 32'h0);
    checkOutput("collision_rdata", 32'(rdata), 32'h0A08);
    checkOutput("collision_no_dp_rst", 32'(sawRst), 32'h0);
    rready = 2'b01;
    stepCycle();
    rready = 2'b00;

    $display("[TB] backpressure");
    latCfg = 2;
    applyStimulus(2'b01, 16'h0007, 16'h0009, 16'h0000, 16'h0000, 2'b00);
    n = 0;
    while (!dp_start && n < 10) begin stepCycle(); n++; end
    req = 2'b00;
    n = 0;
    while (rvalid == 2'b00 && n < 50) begin stepCycle(); n++; end
    applyStimulus(2'b10, 16'h0007, 16'h0009, 16'h0011, 16'h0022, 2'b00);
    held = rdata; stableOk = 1'b1; sawGnt = 1'b0;
    repeat (50) begin
      stepCycle();
      if (rvalid != 2'b01 || rdata != held) stableOk = 1'b0;
      if (gnt != 2'b00) sawGnt = 1'b1;
    end
    checkOutput("bp_rdata", 32'(held), 32'h003F);
    checkOutput("bp_stable", 32'(stableOk), 32'h1);
    checkOutput("bp_no_grant", 32'(sawGnt), 32'h0);
    rready = 2'b01;
    stepCycle();
    checkOutput("bp_idle_rvalid", 32'(rvalid), 32'h0);
    checkOutput("bp_idle_gnt", 32'(gnt), 32'h0);
    stepCycle();
    checkOutput("bp_gnt1", 32'(gnt), 32'h2);
    req = 2'b00;
    rready = 2'b10;
    n = 0;
    while (busy && n < 100) begin stepCycle(); n++; end
    rready = 2'b00;

    $display("[TB] reset during BUSY");
    latCfg = 0;
    applyStimulus(2'b10, 16'h0000, 16'h0000, 16'hBEEF, 16'h0101, 2'b00);
    n = 0;
    while (!dp_start && n < 10) begin stepCycle(); n++; end
    req = 2'b00;
    repeat (5) stepCycle();
    checkOutput("midbusy_busy", 32'(busy), 32'h1);
    checkOutput("midbusy_dp_a", 32'(dp_a), 32'hBEEF);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_busy", 32'(busy), 32'h0);
    checkOutput("async_dp_a", 32'(dp_a), 32'h0);
    checkOutput("async_dp_b", 32'(dp_b), 32'h0);
    checkOutput("async_rdata", 32'(rdata), 32'h0);
    stepCycle();
    rst = 1'b0;
    applyStimulus(2'b11, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 2'b11);
    n = 0;
    while (gnt == 2'b00 && n < 10) begin stepCycle(); n++; end
    checkOutput("post_reset_first_gnt", 32'(gnt), 32'h1);

    $display("[TB] randomized traffic");
    strayEn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      stepCycle();
      nr = req;
      if (mActive && cyc == mG) nr[mOwner] = 1'b0;
      for (int i = 0; i < 2; i++) if (!nr[i] && $urandom_range(0, 3) == 0) nr[i] = 1'b1;
      pick = $urandom_range(0, 15);
      latCfg = (pick == 0) ? 0 : (pick == 1) ? TO : (pick == 2) ? TO + 1 : $urandom_range(1, 6);
      applyStimulus(nr, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                    {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)});
    end
    strayEn = 1'b0;
    stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one normalizing multiply datapath between two requesters.
- Arbitrates round-robin, captures the winner's operands and pulses the datapath start.
- Waits for the datapath done, or for a timeout, then returns the result to the winner over a valid/ready handshake.
- Sits between the request-side logic and the datapath controller's start/Done interface.

Parameters:
- WIDTH, 16, operand width (A and B).
- RES_W, 16, datapath result width.
- TIMEOUT, 255, max cycles in BUSY before abort; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  request per requester; level, held until gnt.
- a0  in  WIDTH  operand A, requester 0.
- b0  in  WIDTH  operand B, requester 0.
- a1  in  WIDTH  operand A, requester 1.
- b1  in  WIDTH  operand B, requester 1.
- gnt  out  2  one-hot, one-cycle grant pulse; operands captured this cycle.
- rvalid  out  2  one-hot result valid.
- rdata  out  RES_W  result, shared by both requesters.
- rerr  out  1  qualifies rvalid; 1 = operation timed out, rdata=0.
- rready  in  2  result accept per requester.
- dp_start  out  1  start to datapath.
- dp_a  out  WIDTH  registered operand A to datapath.
- dp_b  out  WIDTH  registered operand B to datapath.
- dp_done  in  1  datapath done pulse.
- dp_result  in  RES_W  datapath result, valid with dp_done.
- dp_rst  out  1  datapath synchronous reset, one-cycle pulse on timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; last-served pointer=1, so requester 0 wins first; owner=0. All outputs 0: gnt, rvalid, rdata, rerr, dp_start, dp_a, dp_b, dp_rst, busy. Timeout counter=0.
- Reset mid-operation aborts everything immediately; no result is delivered. The datapath is not reset by this block except via dp_rst.
- IDLE:
  - If any req bit is set, the winner is the requesting index that is not the last-served one; with a single request, that requester wins.
  - Same edge: latch winner's a/b into dp_a/dp_b, set owner, pulse gnt[owner] (registered, high the following cycle), go to START.
- START: dp_start=1 for exactly one cycle, then go to BUSY; clear timeout counter. The datapath latches operands when start falls, so dp_a/dp_b stay stable from START until leaving BUSY.
- BUSY:
  - Counter increments each cycle.
  - dp_done=1: capture dp_result into rdata, rerr=0, go to RESP.
  - Else, when counter reaches TIMEOUT: rdata=0, rerr=1, dp_rst=1 for one cycle, go to RESP.
  - dp_done on the same cycle the counter reaches TIMEOUT: done wins, rerr=0.
- RESP:
  - rvalid[owner]=1; rdata and rerr are held stable.
  - On rready[owner]=1: rvalid drops next edge, last-served pointer=owner, go to IDLE.
  - rready of the non-owner is ignored.
- Requests seen in START/BUSY/RESP are not granted. They stay pending and are arbitrated in IDLE.
- Minimum IDLE→IDLE turnaround: 4 cycles plus datapath latency.
- req deasserted after gnt has no effect; the result is still presented.
- dp_done outside BUSY is ignored.
- busy=1 in START, BUSY, RESP.

Test Plan:
- Single request: req=01, a0=0x0003, b0=0x0005; datapath model returns 0x000F after 10 cycles → gnt=01 one cycle, dp_start one pulse with dp_a=3, dp_b=5; rvalid=01, rdata=0x000F, rerr=0; cleared one cycle after rready=01.
- Simultaneous after reset: req=11 held, rready always 1 → grants in order 01, 10, 01, 10; each result routed to the matching rvalid bit.
- Timeout: TIMEOUT=20, model never asserts dp_done → dp_rst pulses 21 cycles after dp_start; rvalid[owner]=1, rerr=1, rdata=0.
- Done/timeout collision: dp_done on the cycle the counter reaches TIMEOUT → rerr=0, rdata=dp_result, no dp_rst.
- Backpressure: hold rready=0 for 50 cycles in RESP, req1 asserted → rvalid and rdata stable, no gnt[1]; gnt[1] pulses on the first IDLE cycle after rready.
- Async reset mid-BUSY: rst asserted off-edge → all outputs 0 immediately; after release, req=11 grants requester 0 first.
